// File: rtl/sweep_pkg.sv
// Shared definitions for the servo sweep controller: FSM state encoding,
// position/voltage widths, reset constants and the position-step helper.
package sweep_pkg;

  localparam int POS_W = 8;
  localparam int V_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE    = 3'd1,
    ST_CONVERT = 3'd2,
    ST_COMPARE = 3'd3,
    ST_NEXT    = 3'd4,
    ST_PARK    = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  localparam logic [V_W-1:0]   RST_MAX_V    = '0;
  localparam logic [POS_W-1:0] RST_BEST_POS = '0;

  // Advance a position by one step, clamping at pos_max. The sum is one bit
  // wider than a position so a large step can never wrap past zero.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                               input int step,
                                               input int pos_max);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + (POS_W+1)'(step);
    if (sum > (POS_W+1)'(pos_max)) return POS_W'(pos_max);
    return sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter shared by the settle (MOVE/PARK) and ADC-timeout
// (CONVERT) waits. expired is high whenever the count has reached zero.
module settle_timer #(
  parameter int W = 10
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] count_reg;

  // Load on request, otherwise count down and rest at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                count_reg <= '0;
    else if (load)             count_reg <= load_val;
    else if (count_reg != '0)  count_reg <= count_reg - 1'b1;
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/sweep_controller.sv
// Servo sweep controller: steps a servo from POS_MIN to POS_MAX, samples the
// PV voltage at each position, tracks the maximum and parks at the best spot.
// Optional feature: define ADC_TIMEOUT_EN to bound the wait for ADC_DONE and
// raise the sticky ERR flag on expiry; otherwise ERR is tied low.
module sweep_controller
  import sweep_pkg::*;
#(
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 180,
  parameter int POS_STEP    = 1,
  parameter int SETTLE_CYC  = 1000,
  parameter int ADC_TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [V_W-1:0]   ADC_DATA,
  input  logic             ADC_DONE,
  output logic             ADC_START,
  output logic [POS_W-1:0] POS,
  output logic             BUSY,
  output logic             DONE,
  output logic [V_W-1:0]   MAX_V,
  output logic [POS_W-1:0] BEST_POS,
  output logic             ERR
);

  // The timer is sized for the longer of the two delays it may be loaded with.
  localparam int TMR_MAX = (SETTLE_CYC > ADC_TIMEOUT) ? SETTLE_CYC : ADC_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [POS_W-1:0] POS_MIN_C   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0] POS_MAX_C   = POS_W'(POS_MAX);

`ifdef ADC_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(ADC_TIMEOUT - 1);
  logic err_reg, err_next;
`endif

  state_t           state_reg, state_next;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic [V_W-1:0]   max_v_reg, max_v_next;
  logic [POS_W-1:0] best_pos_reg, best_pos_next;
  logic [V_W-1:0]   sample_reg, sample_next;
  logic             adc_start_reg, adc_start_next;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_expired;

  settle_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expired  (tmr_expired)
  );

  // Next-state and datapath decisions; timer loads happen on state entry.
  always_comb begin
    state_next    = state_reg;
    pos_next      = pos_reg;
    max_v_next    = max_v_reg;
    best_pos_next = best_pos_reg;
    sample_next   = sample_reg;
    tmr_load      = 1'b0;
    tmr_load_val  = SETTLE_LOAD;
`ifdef ADC_TIMEOUT_EN
    err_next      = err_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (START) begin
          pos_next      = POS_MIN_C;
          max_v_next    = '0;
          best_pos_next = POS_MIN_C;
`ifdef ADC_TIMEOUT_EN
          err_next      = 1'b0;
`endif
          tmr_load      = 1'b1;
          state_next    = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (tmr_expired) begin
`ifdef ADC_TIMEOUT_EN
          tmr_load     = 1'b1;
          tmr_load_val = TMO_LOAD;
`endif
          state_next   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (ADC_DONE) begin
          sample_next = ADC_DATA;
          state_next  = ST_COMPARE;
        end
`ifdef ADC_TIMEOUT_EN
        else if (tmr_expired) begin
          err_next    = 1'b1;
          sample_next = '0;
          state_next  = ST_COMPARE;
        end
`endif
      end
      ST_COMPARE: begin
        // Strictly greater: ties keep the earliest position.
        if (sample_reg > max_v_reg) begin
          max_v_next    = sample_reg;
          best_pos_next = pos_reg;
        end
        state_next = ST_NEXT;
      end
      ST_NEXT: begin
        tmr_load = 1'b1;
        if (pos_reg == POS_MAX_C) begin
          pos_next   = best_pos_reg;
          state_next = ST_PARK;
        end else begin
          pos_next   = step_pos(pos_reg, POS_STEP, POS_MAX);
          state_next = ST_MOVE;
        end
      end
      ST_PARK: begin
        if (tmr_expired) state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    adc_start_next = (state_reg == ST_MOVE) && (state_next == ST_CONVERT);
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg     <= ST_IDLE;
      pos_reg       <= POS_MIN_C;
      max_v_reg     <= RST_MAX_V;
      best_pos_reg  <= RST_BEST_POS;
      sample_reg    <= '0;
      adc_start_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pos_reg       <= pos_next;
      max_v_reg     <= max_v_next;
      best_pos_reg  <= best_pos_next;
      sample_reg    <= sample_next;
      adc_start_reg <= adc_start_next;
    end
  end

`ifdef ADC_TIMEOUT_EN
  // Sticky timeout flag, cleared only by reset or a new sweep.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) err_reg <= 1'b0;
    else        err_reg <= err_next;
  end
  assign ERR = err_reg;
`else
  assign ERR = 1'b0;
`endif

  assign ADC_START = adc_start_reg;
  assign POS       = pos_reg;
  assign BUSY      = (state_reg != ST_IDLE);
  assign DONE      = (state_reg == ST_FINISH);
  assign MAX_V     = max_v_reg;
  assign BEST_POS  = best_pos_reg;

endmodule

// File: tb/tb_sweep_controller.sv
// Directed bench for sweep_controller: a table of sample sets run through a
// POS_MAX=4 / SETTLE_CYC=3 instance, plus reset, repeated-START, step-3 and
// (with ADC_TIMEOUT_EN) timeout sequences.
module tb_sweep_controller;

  localparam int LAT    = 2;
  localparam int BUDGET = 1000;

  typedef struct packed {
    logic [0:4][7:0] smp;
    logic [7:0]      exp_max;
    logic [7:0]      exp_best;
  } vec_t;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rst_n;
  // instance A: step 1
  logic       start_a, adc_done_a, adc_start_a, busy_a, done_a, err_a;
  logic [7:0] adc_data_a, pos_a, max_v_a, best_a;
  // instance B: step 3
  logic       start_b, adc_done_b, adc_start_b, busy_b, done_b, err_b;
  logic [7:0] adc_data_b, pos_b, max_v_b, best_b;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] smp_a [8];
  logic [7:0] smp_b [8];
  logic [7:0] pos_log_a [8];
  logic [7:0] pos_log_b [8];
  int starts_a, done_cnt_a, resp_idx_a;
  int starts_b, done_cnt_b, resp_idx_b;
  logic withhold_a = 1'b0;
  int   withhold_idx_a = 0;

  vec_t vecs [6];

  sweep_controller #(.POS_MIN(0), .POS_MAX(4), .POS_STEP(1), .SETTLE_CYC(3), .ADC_TIMEOUT(8)) dut_a (
    .CLK(clk), .RST_N(rst_n), .START(start_a), .ADC_DATA(adc_data_a), .ADC_DONE(adc_done_a),
    .ADC_START(adc_start_a), .POS(pos_a), .BUSY(busy_a), .DONE(done_a),
    .MAX_V(max_v_a), .BEST_POS(best_a), .ERR(err_a)
  );

  sweep_controller #(.POS_MIN(0), .POS_MAX(4), .POS_STEP(3), .SETTLE_CYC(3), .ADC_TIMEOUT(8)) dut_b (
    .CLK(clk), .RST_N(rst_n), .START(start_b), .ADC_DATA(adc_data_b), .ADC_DONE(adc_done_b),
    .ADC_START(adc_start_b), .POS(pos_b), .BUSY(busy_b), .DONE(done_b),
    .MAX_V(max_v_b), .BEST_POS(best_b), .ERR(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Pulse and position monitors (every ADC_START cycle and DONE cycle counted).
  initial begin
    forever begin
      @(negedge clk);
      if (adc_start_a) begin
        if (starts_a < 8) pos_log_a[starts_a] = pos_a;
        starts_a++;
      end
      if (done_a) done_cnt_a++;
      if (adc_start_b) begin
        if (starts_b < 8) pos_log_b[starts_b] = pos_b;
        starts_b++;
      end
      if (done_b) done_cnt_b++;
    end
  end

  // ADC model for A: answers LAT cycles after a request; data is junk when not done.
  initial begin
    int idx;
    adc_done_a = 1'b0; adc_data_a = 8'hFF;
    forever begin
      @(negedge clk);
      if (adc_start_a) begin
        idx = resp_idx_a; resp_idx_a++;
        if (!(withhold_a && idx == withhold_idx_a)) begin
          repeat (LAT) @(negedge clk);
          adc_data_a = smp_a[idx % 8]; adc_done_a = 1'b1;
          @(negedge clk);
          adc_done_a = 1'b0; adc_data_a = 8'hFF;
        end
      end
    end
  end

  // ADC model for B.
  initial begin
    int idx;
    adc_done_b = 1'b0; adc_data_b = 8'hFF;
    forever begin
      @(negedge clk);
      if (adc_start_b) begin
        idx = resp_idx_b; resp_idx_b++;
        repeat (LAT) @(negedge clk);
        adc_data_b = smp_b[idx % 8]; adc_done_b = 1'b1;
        @(negedge clk);
        adc_done_b = 1'b0; adc_data_b = 8'hFF;
      end
    end
  end

  task automatic clear_a();
    starts_a = 0; done_cnt_a = 0; resp_idx_a = 0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int cyc;
    cyc = 0;
    while (done_cnt_a == 0 && cyc < BUDGET) begin @(posedge clk); cyc++; end
    check({tag, " done_in_budget"}, cyc < BUDGET, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_end_a(input string tag, input logic [7:0] exp_max, input logic [7:0] exp_best,
                             input int exp_starts, input logic exp_err);
    check({tag, " max_v"},    max_v_a, exp_max);
    check({tag, " best_pos"}, best_a, exp_best);
    check({tag, " pos"},      pos_a, exp_best);
    check({tag, " busy"},     busy_a, 0);
    check({tag, " done_cnt"}, done_cnt_a, 1);
    check({tag, " starts"},   starts_a, exp_starts);
    check({tag, " err"},      err_a, exp_err);
    $display("%s: max_v=%0d best_pos=%0d pos=%0d adc_starts=%0d dones=%0d err=%0d",
             tag, max_v_a, best_a, pos_a, starts_a, done_cnt_a, err_a);
  endtask

  task automatic run_sweep_a(input string tag, input logic [7:0] exp_max, input logic [7:0] exp_best);
    clear_a();
    pulse_start_a();
    check({tag, " busy_after_start"}, busy_a, 1);
    wait_done_a(tag);
    check_end_a(tag, exp_max, exp_best, 5, 1'b0);
    for (int i = 0; i < 5; i++) check($sformatf("%s pos_log%0d", tag, i), pos_log_a[i], i);
  endtask

  task automatic load_vec(input int v);
    for (int i = 0; i < 5; i++) smp_a[i] = vecs[v].smp[i];
  endtask

  initial begin
    int cyc;
    vecs[0] = '{smp: {8'd10, 8'd50, 8'd30, 8'd50, 8'd20}, exp_max: 8'd50,  exp_best: 8'd1};
    vecs[1] = '{smp: {8'd0,  8'd0,  8'd0,  8'd0,  8'd0},  exp_max: 8'd0,   exp_best: 8'd0};
    vecs[2] = '{smp: {8'd5,  8'd4,  8'd3,  8'd2,  8'd1},  exp_max: 8'd5,   exp_best: 8'd0};
    vecs[3] = '{smp: {8'd1,  8'd2,  8'd3,  8'd4,  8'd200}, exp_max: 8'd200, exp_best: 8'd4};
    vecs[4] = '{smp: {8'd7,  8'd7,  8'd7,  8'd7,  8'd7},  exp_max: 8'd7,   exp_best: 8'd0};
    vecs[5] = '{smp: {8'd0,  8'd0,  8'd255, 8'd0, 8'd0},  exp_max: 8'd255, exp_best: 8'd2};

    starts_a = 0; done_cnt_a = 0; resp_idx_a = 0;
    starts_b = 0; done_cnt_b = 0; resp_idx_b = 0;
    for (int i = 0; i < 8; i++) begin
      smp_a[i] = '0; smp_b[i] = '0; pos_log_a[i] = '0; pos_log_b[i] = '0;
    end
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst pos", pos_a, 0);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    check("rst adc_start", adc_start_a, 0);
    check("rst max_v", max_v_a, 0);
    check("rst best_pos", best_a, 0);
    check("rst err", err_a, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of sample sets
    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      run_sweep_a($sformatf("vec%0d", v), vecs[v].exp_max, vecs[v].exp_best);
    end

    // Asynchronous reset during CONVERT at POS=2, then a clean full sweep
    smp_a[0] = 8'd3; smp_a[1] = 8'd9; smp_a[2] = 8'd6; smp_a[3] = 8'd1; smp_a[4] = 8'd2;
    clear_a();
    pulse_start_a();
    cyc = 0;
    while (!(adc_start_a && pos_a == 8'd2) && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("midrst reach_pos2", cyc < BUDGET, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst pos", pos_a, 0);
    check("midrst adc_start", adc_start_a, 0);
    check("midrst busy", busy_a, 0);
    check("midrst done", done_a, 0);
    check("midrst max_v", max_v_a, 0);
    check("midrst best_pos", best_a, 0);
    check("midrst err", err_a, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst idle_after", busy_a, 0);
    $display("midrst: outputs cleared while converting at pos 2");
    run_sweep_a("after_rst", 8'd9, 8'd1);

    // START hammered mid-sweep: no restart, one DONE
    load_vec(0);
    clear_a();
    pulse_start_a();
    cyc = 0;
    while (done_cnt_a == 0 && cyc < BUDGET) begin
      @(posedge clk); #1;
      start_a = (cyc % 7 == 3);
      cyc++;
    end
    start_a = 1'b0;
    check("restart done_in_budget", cyc < BUDGET, 1);
    repeat (60) @(posedge clk);
    #1;
    check_end_a("restart", 8'd50, 8'd1, 5, 1'b0);

    // Step of 3 on instance B: positions 0,3,4
    smp_b[0] = 8'd9; smp_b[1] = 8'd20; smp_b[2] = 8'd4;
    starts_b = 0; done_cnt_b = 0; resp_idx_b = 0;
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    cyc = 0;
    while (done_cnt_b == 0 && cyc < BUDGET) begin @(posedge clk); cyc++; end
    check("step3 done_in_budget", cyc < BUDGET, 1);
    repeat (3) @(posedge clk);
    #1;
    check("step3 starts", starts_b, 3);
    check("step3 pos_log0", pos_log_b[0], 0);
    check("step3 pos_log1", pos_log_b[1], 3);
    check("step3 pos_log2", pos_log_b[2], 4);
    check("step3 max_v", max_v_b, 20);
    check("step3 best_pos", best_b, 3);
    check("step3 pos", pos_b, 3);
    check("step3 done_cnt", done_cnt_b, 1);
    check("step3 busy", busy_b, 0);
    $display("step3: max_v=%0d best_pos=%0d pos=%0d adc_starts=%0d", max_v_b, best_b, pos_b, starts_b);

`ifdef ADC_TIMEOUT_EN
    // ADC_DONE withheld at POS=2: ERR after 8 CONVERT cycles, sample treated as 0
    smp_a[0] = 8'd10; smp_a[1] = 8'd20; smp_a[2] = 8'd99; smp_a[3] = 8'd15; smp_a[4] = 8'd5;
    withhold_a = 1'b1; withhold_idx_a = 2;
    clear_a();
    pulse_start_a();
    cyc = 0;
    while (!(adc_start_a && pos_a == 8'd2) && cyc < BUDGET) begin @(negedge clk); cyc++; end
    check("tmo reach_pos2", cyc < BUDGET, 1);
    repeat (7) @(negedge clk);
    check("tmo err_before", err_a, 0);
    check("tmo pos_during", pos_a, 2);
    @(negedge clk);
    check("tmo err_after", err_a, 1);
    wait_done_a("tmo");
    check_end_a("tmo", 8'd20, 8'd1, 5, 1'b1);
    withhold_a = 1'b0;
    load_vec(2);
    run_sweep_a("tmo_clear", vecs[2].exp_max, vecs[2].exp_best);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected summary before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sweep_controller.md
SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 The block SHALL have these parameters: POS_MIN, 0, lowest servo position code.
REQ-002 POS_MAX, 180, highest servo position code; POS_MIN <= POS_MAX < 256.
REQ-003 POS_STEP, 1, position increment per sweep step; minimum 1.
REQ-004 SETTLE_CYC, 1000, clock cycles the servo settles after each position change; minimum 1.
REQ-005 ADC_TIMEOUT, 255, maximum cycles spent waiting for ADC_DONE; used only when ADC_TIMEOUT_EN is defined.
REQ-006 The block SHALL have these ports: CLK  in  1  system clock; all state changes on its rising edge.
REQ-007 RST_N  in  1  asynchronous, active-low reset.
REQ-008 START  in  1  sweep request; sampled only in IDLE.
REQ-009 ADC_DATA  in  8  converted PV voltage; valid while ADC_DONE=1.
REQ-010 ADC_DONE  in  1  conversion-complete strobe.
REQ-011 ADC_START  out  1  one-cycle conversion request pulse.
REQ-012 POS  out  8  commanded servo position.
REQ-013 BUSY  out  1  high in every state except IDLE.
REQ-014 DONE  out  1  one-cycle pulse when the sweep and park complete.
REQ-015 MAX_V  out  8  largest voltage of the current or last sweep.
REQ-016 BEST_POS  out  8  position at which MAX_V was sampled.
REQ-017 ERR  out  1  sticky ADC-timeout flag; constant 0 when ADC_TIMEOUT_EN is undefined.

Function
REQ-018 The FSM SHALL have states IDLE, MOVE, CONVERT, COMPARE, NEXT, PARK and FINISH.
REQ-019 In IDLE with START=1, the block SHALL set POS=POS_MIN, MAX_V=0, BEST_POS=POS_MIN and ERR=0, then enter MOVE.
REQ-020 MOVE SHALL last exactly SETTLE_CYC cycles and then enter CONVERT.
REQ-021 On the cycle it enters CONVERT, the block SHALL assert ADC_START for exactly one cycle, then wait in CONVERT until ADC_DONE=1.
REQ-022 When ADC_DONE=1 in CONVERT, the block SHALL capture ADC_DATA and enter COMPARE on the next cycle; ADC_DONE in any other state SHALL be ignored.
REQ-023 In COMPARE, the block SHALL set MAX_V to the sample and BEST_POS to POS only if the sample is strictly greater than MAX_V, so ties keep the earliest position; it then enters NEXT.
REQ-024 In NEXT with POS==POS_MAX, the block SHALL enter PARK.
REQ-025 In NEXT with POS+POS_STEP > POS_MAX, POS SHALL become POS_MAX (9-bit compare, no wrap); otherwise POS SHALL become POS+POS_STEP; then the block enters MOVE.
REQ-026 In PARK, the block SHALL set POS=BEST_POS, wait SETTLE_CYC cycles, then enter FINISH.
REQ-027 FINISH SHALL pulse DONE for one cycle and return to IDLE; MAX_V, BEST_POS and POS SHALL hold until the next START.
REQ-028 START while BUSY=1 SHALL be ignored.

Reset
REQ-029 With RST_N=0 at any time, including mid-sweep, the block SHALL immediately enter IDLE with POS=POS_MIN and ADC_START, BUSY, DONE, MAX_V, BEST_POS and ERR all 0.

Configuration
REQ-030 With ADC_TIMEOUT_EN defined, if ADC_DONE has not arrived after ADC_TIMEOUT cycles in CONVERT, the block SHALL set ERR=1, use sample value 0 and enter COMPARE.
REQ-031 With ADC_TIMEOUT_EN undefined, CONVERT SHALL wait indefinitely, no timeout counter SHALL be synthesised, and ERR SHALL be tied to 0.

Structure
REQ-032 The state encoding, the 8-bit position and voltage widths and the reset constants SHALL live in a shared package, sweep_pkg.
REQ-033 The settle and timeout down-counter SHALL be a sub-module, settle_timer, reused by MOVE, PARK and CONVERT.

Verification
All scenarios use POS_MIN=0, POS_MAX=4, POS_STEP=1 and SETTLE_CYC=3 unless stated otherwise.
REQ-034 Samples 10,50,30,50,20 -> MAX_V=50, BEST_POS=1, final POS=1, one DONE pulse, BUSY then low.
REQ-035 Samples all 0 -> MAX_V=0, BEST_POS=0, final POS=0; five ADC_START pulses observed.
REQ-036 POS_STEP=3 -> POS sequence 0,3,4 then park; exactly three ADC_START pulses.
REQ-037 RST_N low during the CONVERT at POS=2 -> all outputs at reset values asynchronously; a new START runs a full sweep.
REQ-038 START pulsed repeatedly mid-sweep -> no restart; DONE pulses once per sweep.
REQ-039 ADC_TIMEOUT_EN defined, ADC_TIMEOUT=8, ADC_DONE withheld at POS=2 -> ERR=1 after 8 cycles; the sweep completes with position 2 treated as sample 0.
